// File: rtl/drf_pkg.sv
// Shared constants, register-kind decode and offset helpers for the DRF I/O port block.
package drf_pkg;

  localparam int unsigned DEF_N_PORTS = 4;
  localparam int unsigned DEF_PORT_W  = 4;
  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_ADDR_W  = 5;
  localparam int unsigned RSVD_RD_VAL = 0;

  typedef enum logic [2:0] {
    REG_OUT,
    REG_IN,
    REG_STATUS,
    REG_MASK,
    REG_RSVD
  } reg_kind_e;

  function automatic int unsigned off_out(input int unsigned i);
    return i;
  endfunction

  function automatic int unsigned off_in(input int unsigned n, input int unsigned i);
    return n + i;
  endfunction

  function automatic int unsigned off_status(input int unsigned n);
    return 2 * n;
  endfunction

  function automatic int unsigned off_mask(input int unsigned n);
    return 2 * n + 1;
  endfunction

  // Classify a register offset for an N-channel block.
  function automatic reg_kind_e reg_kind(input int unsigned n, input int unsigned addr);
    if (addr < n)                   return REG_OUT;
    else if (addr < 2 * n)          return REG_IN;
    else if (addr == off_status(n)) return REG_STATUS;
    else if (addr == off_mask(n))   return REG_MASK;
    else                            return REG_RSVD;
  endfunction

endpackage

// File: rtl/drf_io_sync_chan.sv
// One input channel: 2-flop synchronizer plus change detector against a history copy.
// The history flop and detector exist only when DRF_IO_IRQ_EN is defined.
module drf_io_sync_chan
  import drf_pkg::*;
#(
  parameter int unsigned PORT_W = DEF_PORT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              det_en,
  input  logic [PORT_W-1:0] async_in,
  output logic [PORT_W-1:0] sync_val,
  output logic              change_c
);

  logic [PORT_W-1:0] meta_q;
  logic [PORT_W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_val = sync_q;

`ifdef DRF_IO_IRQ_EN
  logic [PORT_W-1:0] hist_q;

  always_ff @(posedge clk) begin
    if (!rst_n) hist_q <= '0;
    else        hist_q <= sync_q;
  end

  assign change_c = det_en && (sync_q != hist_q);
`else
  logic unused_det;
  assign unused_det = det_en;
  assign change_c   = 1'b0;
`endif

endmodule

// File: rtl/drf_io_ports.sv
// Register-mapped GPIO block: OUT/IN channels, change STATUS (W1C), MASK and level IRQ.
// Optional interrupt logic (STATUS, MASK, change detect, out_irq) enabled by DRF_IO_IRQ_EN.
module drf_io_ports
  import drf_pkg::*;
#(
  parameter int unsigned N_PORTS = DEF_N_PORTS,
  parameter int unsigned PORT_W  = DEF_PORT_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_write_en,
  input  logic                      in_read_en,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [DATA_W-1:0]         in_data,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_data_valid,
  input  logic [N_PORTS*PORT_W-1:0] in_port,
  output logic [N_PORTS*PORT_W-1:0] out_port,
  output logic                      out_irq
);

  reg_kind_e                 kind_c;
  logic [N_PORTS*PORT_W-1:0] out_q;
  logic [N_PORTS*PORT_W-1:0] sync_vals;
  logic [N_PORTS-1:0]        change_c;
  logic [N_PORTS-1:0]        status_q;
  logic [N_PORTS-1:0]        mask_q;
  logic                      det_en_c;
  logic [DATA_W-1:0]         rd_mux_c;
  logic [DATA_W-1:0]         rd_data_q;
  logic                      rd_valid_q;
  logic                      unused_bits;

  assign kind_c      = reg_kind(N_PORTS, 32'(in_addr));
  assign unused_bits = ^{in_data, change_c};

  for (genvar g = 0; g < N_PORTS; g++) begin : g_chan
    drf_io_sync_chan #(
      .PORT_W (PORT_W)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .det_en   (det_en_c),
      .async_in (in_port[g*PORT_W +: PORT_W]),
      .sync_val (sync_vals[g*PORT_W +: PORT_W]),
      .change_c (change_c[g])
    );
  end

  // Read mux sees pre-write register values, so same-cycle writes never leak into the read.
  always_comb begin
    rd_mux_c = DATA_W'(RSVD_RD_VAL);
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (kind_c == REG_OUT && in_addr == ADDR_W'(off_out(i)))
        rd_mux_c = DATA_W'(out_q[i*PORT_W +: PORT_W]);
      if (kind_c == REG_IN && in_addr == ADDR_W'(off_in(N_PORTS, i)))
        rd_mux_c = DATA_W'(sync_vals[i*PORT_W +: PORT_W]);
    end
    if (kind_c == REG_STATUS) rd_mux_c = DATA_W'(status_q);
    if (kind_c == REG_MASK)   rd_mux_c = DATA_W'(mask_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= in_read_en;
      if (in_read_en) rd_data_q <= rd_mux_c;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        if (in_write_en && kind_c == REG_OUT && in_addr == ADDR_W'(off_out(i)))
          out_q[i*PORT_W +: PORT_W] <= in_data[PORT_W-1:0];
      end
    end
  end

  assign out_port       = out_q;
  assign out_data_valid = rd_valid_q;
  assign out_data       = rd_valid_q ? rd_data_q : {DATA_W{1'bz}};

`ifdef DRF_IO_IRQ_EN
  logic [1:0]         settle_q;
  logic [N_PORTS-1:0] clr_c;
  logic               irq_q;

  // Detection stays off until the synchronizers and history have absorbed power-up levels.
  assign det_en_c = (settle_q == 2'd3);
  assign clr_c    = (in_write_en && kind_c == REG_STATUS) ? in_data[N_PORTS-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_q <= 2'd0;
      status_q <= '0;
      mask_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      status_q <= (status_q & ~clr_c) | change_c;
      if (in_write_en && kind_c == REG_MASK) mask_q <= in_data[N_PORTS-1:0];
      irq_q <= |(status_q & mask_q);
    end
  end

  assign out_irq = irq_q;
`else
  assign det_en_c = 1'b0;
  assign status_q = '0;
  assign mask_q   = '0;
  assign out_irq  = 1'b0;
`endif

endmodule

// File: doc/drf_io_ports.md
DRF_IO_PORTS -- requirements
Module: drf_io_ports

Interface
REQ-001 Parameter N_PORTS, default 4, number of independent I/O channels; legal range 1..8.
REQ-002 Parameter PORT_W, default 4, width of each channel; legal range 1..DATA_W.
REQ-003 Parameter DATA_W, default 8, width of the data bus.
REQ-004 Parameter ADDR_W, default 5, register-offset width; must satisfy 2^ADDR_W >= 2*N_PORTS+2.
REQ-005 The block SHALL use one clock; reset is synchronous and active-low.
REQ-006 Port clk, input, 1 bit, system clock; all logic SHALL be sampled on its rising edge.
REQ-007 Port rst_n, input, 1 bit, synchronous active-low reset.
REQ-008 Port in_write_en, input, 1 bit, bus write strobe.
REQ-009 Port in_read_en, input, 1 bit, bus read strobe.
REQ-010 Port in_addr, input, ADDR_W bits, register offset.
REQ-011 Port in_data, input, DATA_W bits, write data.
REQ-012 Port out_data, output, DATA_W bits, read data; driven while out_data_valid=1 and high-Z otherwise (shared bus).
REQ-013 Port out_data_valid, output, 1 bit, read data present.
REQ-014 Port in_port, input, N_PORTS*PORT_W bits, asynchronous external inputs; channel i occupies bits [i*PORT_W +: PORT_W].
REQ-015 Port out_port, output, N_PORTS*PORT_W bits, registered external outputs, same packing.
REQ-016 Port out_irq, output, 1 bit, level interrupt request.

Function
REQ-017 The offset map SHALL be: 0..N-1 OUT[i] (R/W); N..2N-1 IN[i] (R/O); 2N STATUS (R, write-1-to-clear); 2N+1 MASK (R/W); all other offsets reserved.
REQ-018 A write to OUT[i] SHALL update out_port channel i on the next rising edge from in_data[PORT_W-1:0]; upper data bits are ignored.
REQ-019 Each in_port channel SHALL pass through a 2-flop synchronizer; IN[i] SHALL return the second-stage value, zero-extended to DATA_W.
REQ-020 A change detector SHALL compare the synchronized value against a third registered copy; any difference SHALL set STATUS[i] on that edge.
REQ-021 A read SHALL have 1-cycle latency: in_read_en in cycle T gives out_data_valid=1 and data in cycle T+1 only.
REQ-022 A read of OUT[i], STATUS or MASK SHALL return the value held before any same-cycle write.
REQ-023 When in_read_en and in_write_en are both high, the write and the read SHALL both be performed.
REQ-024 When a STATUS write-1-to-clear and a new change event hit the same bit in one cycle, set SHALL win.
REQ-025 Writes to reserved offsets or IN[i] SHALL be ignored; reads of reserved offsets SHALL return 0 with out_data_valid=1.
REQ-026 STATUS and MASK bits at positions N_PORTS..DATA_W-1 SHALL read as 0.
REQ-027 out_irq SHALL equal the registered OR of (STATUS & MASK), asserting 1 cycle after the STATUS bit sets.

Reset
REQ-028 While rst_n=0 at a clock edge, the block SHALL clear out_port, STATUS, MASK, all synchronizer and history flops, out_data_valid and out_irq to 0.
REQ-029 Change detection SHALL be suppressed for the first 3 cycles after reset release, so that power-up input levels raise no STATUS bits.
REQ-030 A reset that arrives while a read is pending SHALL discard the read; out_data_valid SHALL be 0 in the following cycle.

Configuration
REQ-031 With DRF_IO_IRQ_EN defined, the MASK register, the change detector and out_irq SHALL be implemented as specified.
REQ-032 With DRF_IO_IRQ_EN undefined, STATUS and MASK SHALL read 0 and ignore writes, out_irq SHALL be tied 0, and no history flops SHALL exist.

Structure
REQ-033 The shared package drf_pkg SHALL hold the offset-computation functions, the default parameter constants and the reserved-read value.
REQ-034 Each channel's synchronizer plus change detector SHALL be one sub-module, drf_io_sync_chan, instantiated N_PORTS times by a generate loop.

Verification
REQ-035 Reset, then write OUT[2]=8'hA5 (N=4, W=4) -> out_port[11:8]=4'h5 on the next edge; a read of offset 2 returns 8'h05, valid 1 cycle later.
REQ-036 in_port[3:0]: 0->4'h9 -> IN[0] reads 8'h09 after 2 edges; STATUS[0]=1 on edge 3; with MASK=8'h01, out_irq=1 on edge 4.
REQ-037 STATUS=8'h01; write 8'h01 to offset 8 in the same cycle that channel 0 changes again -> STATUS[0] stays 1 and out_irq stays 1.
REQ-038 Read offset 31 -> out_data=8'h00 with out_data_valid=1; write offset 31 -> no register changes.
REQ-039 Drive in_port nonzero during reset and release rst_n -> STATUS=0 and out_irq=0 for 10 cycles.
REQ-040 Build without DRF_IO_IRQ_EN and toggle in_port -> STATUS/MASK read 0 and out_irq=0 throughout.
